// File: rtl/song_sequencer.sv
// song_sequencer
// Plays the selected song from a synchronous note ROM. Each ROM entry holds
// a note code in [15:8] and a duration in beat units in [7:0]. Every entry
// that has a non-zero duration sounds for duration*BEAT_CYCLES clocks and
// is followed by a silent gap of GAP_CYCLES clocks. Code 8'hFF marks the end
// of a song, and the song then loops. Changing the selection restarts playback
// from the new song's base address straight away.
module song_sequencer #(
    parameter int                 ADDR_W      = 8,
    parameter int                 BEAT_CYCLES = 3125000,
    parameter int                 GAP_CYCLES  = 250000,
    parameter logic [ADDR_W-1:0]  BASE1       = ADDR_W'(8'h00),
    parameter logic [ADDR_W-1:0]  BASE2       = ADDR_W'(8'h40),
    parameter logic [ADDR_W-1:0]  BASE3       = ADDR_W'(8'h80)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        song_sel,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        note_code,
    output logic              note_on,
    output logic              song_done,
    output logic              busy
);

    // Counter widths. A minimum of one bit keeps the counters legal when a
    // period of a single cycle is requested.
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    localparam logic [7:0] END_MARKER = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [3:0]        song_latched;
    logic [BEAT_W-1:0] beat_cnt;
    logic [7:0]        unit_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              sel_valid;
    logic              sel_changed;
    logic [ADDR_W-1:0] sel_base;
    logic [ADDR_W-1:0] song_base;
    logic [7:0]        rom_code;
    logic [7:0]        rom_dur;
    logic              is_marker;
    logic              is_skip;
    logic              beat_wrap;
    logic              play_done;
    logic              gap_last;

    // Maps a selection code to the base address of its song. Only the three
    // valid codes ever reach this lookup in a way that matters.
    function automatic logic [ADDR_W-1:0] base_of(input logic [3:0] sel);
        logic [ADDR_W-1:0] base;
        case (sel)
            4'b0010: base = BASE2;
            4'b0011: base = BASE3;
            default: base = BASE1;
        endcase
        return base;
    endfunction

    assign sel_valid   = (song_sel == 4'b0001) || (song_sel == 4'b0010) ||
                         (song_sel == 4'b0011);
    assign sel_changed = (song_sel != song_latched);
    assign sel_base    = base_of(song_sel);
    assign song_base   = base_of(song_latched);

    assign rom_code    = rom_data[15:8];
    assign rom_dur     = rom_data[7:0];
    assign is_marker   = (rom_code == END_MARKER);
    assign is_skip     = (rom_dur == 8'd0);

    assign beat_wrap   = (beat_cnt == BEAT_LAST);
    assign play_done   = beat_wrap && (unit_cnt == 8'd1);
    assign gap_last    = (gap_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; a song change overrides everything else once playing.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (sel_valid) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_LOAD;
            S_LOAD: begin
                if (is_marker || is_skip) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!pause && play_done) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (!pause && gap_last) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if ((state != S_IDLE) && sel_changed) begin
            state_next = sel_valid ? S_FETCH : S_IDLE;
        end
    end

    // Datapath: address, latched song, note code, counters and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr     <= '0;
            song_latched <= 4'd0;
            note_code    <= 8'd0;
            song_done    <= 1'b0;
            beat_cnt     <= '0;
            unit_cnt     <= 8'd0;
            gap_cnt      <= '0;
        end else begin
            song_done <= 1'b0;

            if (state == S_IDLE) begin
                if (sel_valid) begin
                    song_latched <= song_sel;
                    rom_addr     <= sel_base;
                end
            end else if (sel_changed) begin
                note_code <= 8'd0;
                beat_cnt  <= '0;
                unit_cnt  <= 8'd0;
                gap_cnt   <= '0;
                if (sel_valid) begin
                    song_latched <= song_sel;
                    rom_addr     <= sel_base;
                end
            end else begin
                case (state)
                    S_LOAD: begin
                        if (is_marker) begin
                            song_done <= 1'b1;
                            rom_addr  <= song_base;
                        end else if (is_skip) begin
                            rom_addr  <= rom_addr + 1'b1;
                        end else begin
                            note_code <= rom_code;
                            unit_cnt  <= rom_dur;
                            beat_cnt  <= '0;
                        end
                    end
                    S_PLAY: begin
                        if (!pause) begin
                            if (beat_wrap) begin
                                beat_cnt <= '0;
                                unit_cnt <= unit_cnt - 8'd1;
                                if (unit_cnt == 8'd1) begin
                                    note_code <= 8'd0;
                                    gap_cnt   <= '0;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (!pause) begin
                            if (gap_last) begin
                                gap_cnt  <= '0;
                                rom_addr <= rom_addr + 1'b1;
                            end else begin
                                gap_cnt  <= gap_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decoded from state; pause silences a sounding note without delay.
    always_comb begin
        busy    = (state != S_IDLE);
        note_on = (state == S_PLAY) && (note_code != 8'd0) && !pause;
    end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer
// Randomised bench for song_sequencer. A reference model expands every ROM
// entry into the list of clock cycles it should produce (fetch overhead, note
// time, gap time) and pushes the expected outputs of each cycle into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_song_sequencer;

    localparam int BEAT_CYC = 4;
    localparam int GAP_CYC  = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  song_sel  = 4'd0;
    logic        pause     = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  note_code;
    logic        note_on;
    logic        song_done;
    logic        busy;

    logic [15:0] rom [256];

    int tests = 0;
    int fails = 0;
    int done_count = 0;
    bit wrap_seen = 1'b0;

    typedef struct {
        logic [7:0] code;
        logic       on;
        logic [7:0] addr;
        logic       done;
        logic       busy;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        logic       on;
        logic [7:0] addr;
        logic       done;
        logic       hold;
    } cyc_t;

    exp_t exp_q[$];
    cyc_t tl[$];

    logic       m_idle      = 1'b1;
    logic [3:0] m_sel       = 4'd0;
    logic [7:0] m_next_addr = 8'd0;
    logic       m_next_done = 1'b0;
    logic [7:0] m_idle_addr = 8'd0;

    song_sequencer #(
        .ADDR_W      (8),
        .BEAT_CYCLES (BEAT_CYC),
        .GAP_CYCLES  (GAP_CYC),
        .BASE1       (8'h00),
        .BASE2       (8'h40),
        .BASE3       (8'h80)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .song_sel  (song_sel),
        .pause     (pause),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_code (note_code),
        .note_on   (note_on),
        .song_done (song_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous note ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic exp_t mkExp(input logic [7:0] code, input logic on,
                                   input logic [7:0] addr, input logic done,
                                   input logic bsy);
        exp_t e;
        e.code = code; e.on = on; e.addr = addr; e.done = done; e.busy = bsy;
        return e;
    endfunction

    function automatic cyc_t mkCyc(input logic [7:0] code, input logic on,
                                   input logic [7:0] addr, input logic done,
                                   input logic hold);
        cyc_t c;
        c.code = code; c.on = on; c.addr = addr; c.done = done; c.hold = hold;
        return c;
    endfunction

    function automatic logic selValid(input logic [3:0] s);
        return (s == 4'd1) || (s == 4'd2) || (s == 4'd3);
    endfunction

    function automatic logic [7:0] baseOf(input logic [3:0] s);
        return (s == 4'd2) ? 8'h40 : (s == 4'd3) ? 8'h80 : 8'h00;
    endfunction

    // Appends the cycles produced by the next ROM entry of the current song.
    task automatic expandEntry();
        logic [15:0] e;
        logic [7:0]  a;
        a = m_next_addr;
        e = rom[a];
        for (int i = 0; i < 3; i++)
            tl.push_back(mkCyc(8'h00, 1'b0, a, (i == 0) ? m_next_done : 1'b0, 1'b0));
        if (e[15:8] == 8'hFF) begin
            m_next_addr = baseOf(m_sel);
            m_next_done = 1'b1;
        end else if (e[7:0] == 8'd0) begin
            m_next_addr = a + 8'd1;
            m_next_done = 1'b0;
        end else begin
            for (int i = 0; i < int'(e[7:0]) * BEAT_CYC; i++)
                tl.push_back(mkCyc(e[15:8], e[15:8] != 8'h00, a, 1'b0, 1'b1));
            for (int i = 0; i < GAP_CYC; i++)
                tl.push_back(mkCyc(8'h00, 1'b0, a, 1'b0, 1'b1));
            m_next_addr = a + 8'd1;
            m_next_done = 1'b0;
        end
    endtask

    task automatic startSong(input logic [3:0] s);
        m_idle      = 1'b0;
        m_sel       = s;
        tl.delete();
        m_next_addr = baseOf(s);
        m_next_done = 1'b0;
    endtask

    // Reference model: advances one timeline cycle per clock using the inputs
    // seen at the edge, then queues the outputs expected for the new cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_idle      = 1'b1;
                m_sel       = 4'd0;
                m_idle_addr = 8'd0;
                tl.delete();
            end else if (m_idle) begin
                if (selValid(song_sel)) startSong(song_sel);
            end else if (song_sel != m_sel) begin
                if (selValid(song_sel)) begin
                    startSong(song_sel);
                end else begin
                    m_idle      = 1'b1;
                    m_idle_addr = tl[0].addr;
                    tl.delete();
                end
            end else if (!(pause && tl[0].hold)) begin
                void'(tl.pop_front());
            end
            if (!m_idle && tl.size() == 0) expandEntry();
            #2;
            if (m_idle)
                exp_q.push_back(mkExp(8'h00, 1'b0, m_idle_addr, 1'b0, 1'b0));
            else
                exp_q.push_back(mkExp(tl[0].code, tl[0].on && !pause, tl[0].addr,
                                      tl[0].done, 1'b1));
        end
    end

    task automatic checkOutput(input string name, input exp_t ex, input bit chk_addr);
        bit ok;
        ok = (note_code === ex.code) && (note_on === ex.on) &&
             (song_done === ex.done) && (busy === ex.busy) &&
             (!chk_addr || (rom_addr === ex.addr));
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got code=%02h on=%0b addr=%02h done=%0b busy=%0b, expected code=%02h on=%0b addr=%02h done=%0b busy=%0b",
                     name, $time, note_code, note_on, rom_addr, song_done, busy,
                     ex.code, ex.on, ex.addr, ex.done, ex.busy);
        end
    endtask

    // Monitor: compares every cycle against the scoreboard and notes events.
    initial begin
        logic [7:0] prev_addr;
        logic       prev_busy;
        exp_t       ex;
        prev_addr = 8'h00;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                checkOutput("scoreboard", ex, 1'b1);
            end
            if (song_done === 1'b1) done_count++;
            if (busy && prev_busy && prev_addr == 8'hFF && rom_addr == 8'h00)
                wrap_seen = 1'b1;
            prev_addr = rom_addr;
            prev_busy = busy;
        end
    end

    task automatic applyStimulus(input logic [3:0] sel, input logic p, input int n);
        song_sel = sel;
        pause    = p;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitNote(input logic level, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (note_on === level) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL %s: note_on never reached %0b within 200 cycles", name, level);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h0502;
        rom[8'h01] = 16'h0001;
        rom[8'h02] = 16'hFF00;
        rom[8'h40] = 16'h0A01;
        rom[8'h41] = 16'h0700;
        rom[8'h42] = 16'h0C02;
        rom[8'h43] = 16'h0000;
        rom[8'h44] = 16'h0001;
        rom[8'h45] = 16'hFF00;
        rom[8'h80] = 16'h2102;
        for (int i = 8'h81; i <= 8'hFF; i++)
            rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 2))};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_values", mkExp(8'h00, 1'b0, 8'h00, 1'b0, 1'b0), 1'b1);
        rst_n = 1'b1;
        applyStimulus(4'd0, 1'b0, 2);

        // First song: latch, fixed latency, note length and gap.
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("latch_base1", mkExp(8'h00, 1'b0, 8'h00, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0001, 1'b0, 3);
        checkOutput("first_note_on", mkExp(8'h05, 1'b1, 8'h00, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0001, 1'b0, 7);
        checkOutput("note_last_cycle", mkExp(8'h05, 1'b1, 8'h00, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0001, 1'b0, 1);
        checkOutput("gap_start", mkExp(8'h00, 1'b0, 8'h00, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0001, 1'b0, 60);

        // Pause mid-note for 10 cycles.
        waitNote(1'b0, "pause_wait_off");
        waitNote(1'b1, "pause_wait_on");
        applyStimulus(4'b0001, 1'b0, 2);
        pause = 1'b1;
        #1;
        checkOutput("pause_silences", mkExp(8'h05, 1'b0, 8'h00, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0001, 1'b1, 10);
        checkOutput("pause_holds", mkExp(8'h05, 1'b0, 8'h00, 1'b0, 1'b1), 1'b1);
        pause = 1'b0;
        #1;
        checkOutput("pause_release", mkExp(8'h05, 1'b1, 8'h00, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0001, 1'b0, 30);

        // Song change mid-note, then run song 3 long enough to wrap the address.
        waitNote(1'b0, "change_wait_off");
        waitNote(1'b1, "change_wait_on");
        applyStimulus(4'b0011, 1'b0, 1);
        checkOutput("change_abort", mkExp(8'h00, 1'b0, 8'h80, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0011, 1'b0, 3);
        checkOutput("change_new_note", mkExp(8'h21, 1'b1, 8'h80, 1'b0, 1'b1), 1'b1);
        applyStimulus(4'b0011, 1'b0, 2000);
        tests++;
        if (!wrap_seen) begin
            fails++;
            $display("[TB] FAIL addr_wrap: got wrap_seen=%0b, expected 1", wrap_seen);
        end

        // Invalid selection returns to idle.
        applyStimulus(4'b0100, 1'b0, 1);
        checkOutput("invalid_idle", mkExp(8'h00, 1'b0, 8'h00, 1'b0, 1'b0), 1'b0);
        applyStimulus(4'b0100, 1'b0, 5);

        // Randomised selection changes and pauses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 7))
                    0: song_sel = 4'b0000;
                    1, 4: song_sel = 4'b0001;
                    2, 5: song_sel = 4'b0010;
                    3, 6: song_sel = 4'b0011;
                    default: song_sel = 4'b1111;
                endcase
            end
            if ($urandom_range(0, 24) == 0) pause = ~pause;
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a note.
        applyStimulus(4'b0001, 1'b0, 5);
        waitNote(1'b0, "reset_wait_off");
        waitNote(1'b1, "reset_wait_on");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", mkExp(8'h00, 1'b0, 8'h00, 1'b0, 1'b0), 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0001, 1'b0, 40);

        tests++;
        if (done_count == 0) begin
            fails++;
            $display("[TB] FAIL song_done_seen: got %0d pulses, expected at least 1", done_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
